// File: rtl/seq_alu_if.sv
// rtl/seq_alu_if.sv - request/result handshake bundle for seq_alu
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       code;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Z;
  logic             CMP_Flag;

  modport master (
    output in_valid, code, X, Y, out_ready,
    input  in_ready, out_valid, Z, CMP_Flag
  );

  modport slave (
    input  in_valid, code, X, Y, out_ready,
    output in_ready, out_valid, Z, CMP_Flag
  );
endinterface

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - sequential ALU: single-cycle ops plus shift-add multiply
// Optional saturating add/sub (opcodes 13/14) enabled by macro SEQ_ALU_SAT_EN.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  seq_alu_if.slave   bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]    LAST_STEP = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] SHIFT_LIM = WIDTH'(WIDTH);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

  localparam logic [5:0] OP_ADD  = 6'd0;
  localparam logic [5:0] OP_SUB  = 6'd1;
  localparam logic [5:0] OP_MUL  = 6'd2;
  localparam logic [5:0] OP_AND  = 6'd3;
  localparam logic [5:0] OP_OR   = 6'd4;
  localparam logic [5:0] OP_XOR  = 6'd5;
  localparam logic [5:0] OP_NOT  = 6'd6;
  localparam logic [5:0] OP_MAX  = 6'd7;
  localparam logic [5:0] OP_LT   = 6'd8;
  localparam logic [5:0] OP_EQ   = 6'd9;
  localparam logic [5:0] OP_LE   = 6'd10;
  localparam logic [5:0] OP_SHL  = 6'd11;
  localparam logic [5:0] OP_SHR  = 6'd12;
`ifdef SEQ_ALU_SAT_EN
  localparam logic [5:0] OP_SADD = 6'd13;
  localparam logic [5:0] OP_SSUB = 6'd14;
`endif

  logic [0:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] z_q;
  logic             flag_q;
  logic             ov_q;

  logic             accept;
  logic [WIDTH-1:0] alu_z;
  logic             alu_is_cmp;
  logic             alu_flag;

  assign bus.in_ready  = (state == ST_IDLE) && (!ov_q || bus.out_ready);
  assign bus.out_valid = ov_q;
  assign bus.Z         = z_q;
  assign bus.CMP_Flag  = flag_q;

  assign accept = bus.in_valid && bus.in_ready;

  // One multiplier bit per cycle; the multiplicand walks left, high bits fall off.
  assign acc_next = mplier[0] ? (acc + mcand) : acc;

`ifdef SEQ_ALU_SAT_EN
  logic [WIDTH:0] sat_sum;
  assign sat_sum = {1'b0, bus.X} + {1'b0, bus.Y};
`endif

  always_comb begin
    alu_z      = '0;
    alu_is_cmp = 1'b0;
    alu_flag   = 1'b0;
    case (bus.code)
      OP_ADD: alu_z = bus.X + bus.Y;
      OP_SUB: alu_z = bus.X - bus.Y;
      OP_AND: alu_z = bus.X & bus.Y;
      OP_OR:  alu_z = bus.X | bus.Y;
      OP_XOR: alu_z = bus.X ^ bus.Y;
      OP_NOT: alu_z = ~bus.Y;
      OP_MAX: alu_z = (bus.X > bus.Y) ? bus.X : bus.Y;
      OP_LT: begin
        alu_is_cmp = 1'b1;
        alu_flag   = bus.X < bus.Y;
      end
      OP_EQ: begin
        alu_is_cmp = 1'b1;
        alu_flag   = bus.X == bus.Y;
      end
      OP_LE: begin
        alu_is_cmp = 1'b1;
        alu_flag   = bus.X <= bus.Y;
      end
      OP_SHL: alu_z = (bus.Y >= SHIFT_LIM) ? '0 : (bus.X << bus.Y);
      OP_SHR: alu_z = (bus.Y >= SHIFT_LIM) ? '0 : (bus.X >> bus.Y);
`ifdef SEQ_ALU_SAT_EN
      OP_SADD: alu_z = sat_sum[WIDTH] ? '1 : sat_sum[WIDTH-1:0];
      OP_SSUB: alu_z = (bus.X < bus.Y) ? '0 : (bus.X - bus.Y);
`endif
      default: alu_z = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      z_q    <= '0;
      flag_q <= 1'b0;
      ov_q   <= 1'b0;
    end else begin
      // Default: a held result drops once the consumer takes it; loads below override.
      ov_q <= ov_q && !bus.out_ready;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (bus.code == OP_MUL) begin
              state  <= ST_MUL;
              cnt    <= '0;
              mcand  <= bus.X;
              mplier <= bus.Y;
              acc    <= '0;
            end else begin
              z_q  <= alu_z;
              ov_q <= 1'b1;
              if (alu_is_cmp) begin
                flag_q <= alu_flag;
              end
            end
          end
        end
        ST_MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST_STEP) begin
            z_q   <= acc_next;
            ov_q  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width in bits (legal 8..64).
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: in_valid  input  1  operation request valid.
REQ-005 SHALL have port: in_ready  output  1  block can accept an operation this cycle.
REQ-006 SHALL have port: code  input  6  opcode.
REQ-007 SHALL have ports: X, Y  input  WIDTH  unsigned operands.
REQ-008 SHALL have port: out_valid  output  1  Z/CMP_Flag hold a result not yet consumed.
REQ-009 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-010 SHALL have port: Z  output  WIDTH  registered result.
REQ-011 SHALL have port: CMP_Flag  output  1  registered compare flag.

Function
REQ-012 SHALL accept an operation on a rising edge where in_valid && in_ready; code/X/Y are captured then and may change afterwards.
REQ-013 SHALL drive in_ready = (state==IDLE) && (!out_valid || out_ready), so a result being consumed and a new accept can share one edge.
REQ-014 SHALL hold Z, CMP_Flag, out_valid stable while out_valid && !out_ready; out_valid clears on an edge with out_ready, unless a new result loads on that edge.
REQ-015 SHALL implement opcodes (all mod 2^WIDTH): 0 X+Y; 1 X-Y; 2 X*Y low WIDTH bits; 3 X&Y; 4 X|Y; 5 X^Y; 6 ~Y; 7 unsigned max(X,Y); 11 X<<Y; 12 X>>Y (logical).
REQ-016 SHALL yield Z=0 for shifts when Y >= WIDTH.
REQ-017 SHALL for 8 (X<Y), 9 (X==Y), 10 (X<=Y) set Z=0 and CMP_Flag to the unsigned comparison result.
REQ-018 SHALL leave CMP_Flag unchanged on every non-compare opcode; undefined opcodes give Z=0, flag unchanged.
REQ-019 SHALL complete all opcodes except 2 with latency 1: accept on edge k -> out_valid high after edge k.
REQ-020 SHALL compute opcode 2 iteratively by shift-add, one multiplier bit per cycle, FSM IDLE->MUL on accept, WIDTH edges in MUL, MUL->IDLE loading result on edge k+WIDTH; out_valid high after edge k+WIDTH.
REQ-021 SHALL keep in_ready low throughout MUL; in_valid during MUL has no effect.
REQ-022 SHALL use a $clog2(WIDTH)+1-bit iteration counter cleared on entry to MUL.

Reset
REQ-023 SHALL on rst_n low, asynchronously: state=IDLE, counter=0, Z=0, CMP_Flag=0, out_valid=0; in_ready then reads 1.
REQ-024 SHALL abandon an in-progress MUL on reset with no result delivered.
REQ-025 SHALL accept no operation on the first edge at which rst_n is sampled low.

Configuration
REQ-026 SHALL, with macro SEQ_ALU_SAT_EN defined, add opcode 13 saturating unsigned add (overflow -> all ones) and 14 saturating unsigned sub (underflow -> 0), latency 1.
REQ-027 SHALL, without SEQ_ALU_SAT_EN, treat opcodes 13 and 14 as undefined (Z=0, flag unchanged) with no saturation logic present.

Verification (WIDTH=32 unless stated)
REQ-028 SHALL cover: code 0, X=0xFFFFFFFF, Y=2, out_ready=1 -> Z=0x00000001 one cycle after accept; then code 9, X=Y=5 -> Z=0, CMP_Flag=1; then code 3 -> CMP_Flag still 1.
REQ-029 SHALL cover: code 2, X=0x10000, Y=0x10003 -> in_ready low 32 cycles, out_valid after edge k+32, Z=0x00030000 (high bits dropped).
REQ-030 SHALL cover: back-to-back code 4 ops with out_ready=0 after first -> second not accepted, Z held; out_ready=1 -> consume and accept on same edge.
REQ-031 SHALL cover: code 11, X=1, Y=32 -> Z=0; code 12, X=0x80000000, Y=31 -> Z=1.
REQ-032 SHALL cover: rst_n low at cycle 10 of a MUL -> out_valid=0, in_ready=1, Z=0 immediately, no result afterwards.
REQ-033 SHALL cover: WIDTH=8 with SEQ_ALU_SAT_EN: code 13, X=0xF0, Y=0x20 -> Z=0xFF; code 14, X=3, Y=5 -> Z=0; without macro both -> Z=0.
